vde_sprite_rasterizer: RTL
==========================

Name: vde_sprite_rasterizer

Overview:
- Consumes the tile stream from the map emitter: one handshake per 8-pixel tile row, carrying a 9-bit sprite index and a row number.
- Fetches the matching 32-bit sprite row (8 pixels × 4 bpp) from sprite memory.
- Serialises it into a 1-pixel-per-cycle palette-index stream with end-of-line and end-of-frame markers for the palette/scanout stage.
- Double-buffered: the next row is prefetched while the current row shifts out, so throughput is sustained.

Parameters:
- MAP_WIDTH, 80, tiles per line (line = MAP_WIDTH*8 pixels).
- LINES, 480, pixel lines per frame (MAP_HEIGHT 60 × 8).

Ports:
- clk_i  in  1  clock.
- rstn_i  in  1  reset; asynchronous, active-low.
- frame_start  in  1  synchronous flush/restart pulse.
- sprite_valid_i  in  1  tile request valid.
- sprite_ready_o  out  1  tile request accepted when high with valid.
- sprite_data_i  in  9  sprite index.
- sprite_row_i  in  4  row in sprite; bit 3 ignored.
- spr_mem_addr_o  out  12  {sprite index, row[2:0]}.
- spr_mem_fetch_o  out  1  fetch request, held until done.
- spr_mem_data_i  in  32  row data; pixel k = bits[4k+3:4k], k=0 leftmost.
- spr_mem_done_i  in  1  data valid this cycle; meaningful only while fetch is high.
- pixel_valid_o  out  1  pixel output valid.
- pixel_ready_i  in  1  downstream accepts pixel.
- pixel_o  out  4  palette index.
- pixel_eol_o  out  1  qualifies pixel: last pixel of a line.
- pixel_eof_o  out  1  qualifies pixel: last pixel of a frame.

Behaviour:
- Reset (rstn_i low, async): all registers clear.
  - spr_mem_fetch_o=0, spr_mem_addr_o=0, pixel_valid_o=0, pixel_o=0, eol/eof=0.
  - Tile counter, line counter and pixel index = 0; pending buffer empty; shifter empty.
  - sprite_ready_o=1 once rstn_i high.
- sprite_ready_o (combinational) = ~frame_start & ~spr_mem_fetch_o & ~pending_valid.
- Fetch stage:
  - Accept on sprite_valid_i & sprite_ready_o.
  - Next edge: spr_mem_addr_o <= {sprite_data_i, sprite_row_i[2:0]}, spr_mem_fetch_o <= 1.
  - Fetch and addr stay stable until spr_mem_done_i is seen with fetch high.
  - On that edge: pending <= spr_mem_data_i, pending_valid <= 1, fetch <= 0.
  - done with fetch low is ignored.
- Shift stage:
  - 32-bit shifter + 3-bit pixel index. pixel_valid_o = shifter_valid; pixel_o = shifter[3:0].
  - On pixel_valid_o & pixel_ready_i: shifter >>= 4, index++.
  - On acceptance of pixel index 7: shifter_valid drops, unless pending_valid. In that case the shifter loads pending in the same edge, pending_valid <= 0, index <= 0, giving no bubble.
  - When the shifter is empty and pending_valid: load on the next edge.
  - Simultaneous memory done and pending→shifter transfer in the same edge is legal: pending is overwritten with the new data and stays valid.
  - Output latency: accept → first pixel_valid_o ≥ 3 cycles, i.e. accept edge, fetch, done edge, load edge. With done in the first fetch cycle it is exactly 3 cycles.
  - Sustained 1 px/cycle when memory latency ≤ 6 cycles.
- Position counters advance on pixel acceptance only:
  - At index 7, tile_x++.
  - When tile_x == MAP_WIDTH-1: tile_x <= 0, line++.
  - When line == LINES-1: line <= 0.
- Markers are combinational from the current position:
  - pixel_eol_o = valid & index==7 & tile_x==MAP_WIDTH-1.
  - pixel_eof_o = pixel_eol_o & line==LINES-1.
- frame_start has highest priority, with the same clearing effect as reset but synchronous:
  - Clears fetch, pending, shifter, counters.
  - A done arriving in the same cycle is discarded; pixel_valid_o is 0 from the next cycle.
  - No tile is accepted in the frame_start cycle.
- Backpressure: while pixel_ready_i is low, pixel_o, eol and eof hold stable. Once pending fills, sprite_ready_o stays low until pending drains.

Test Plan:
- Single tile: reset, send idx 5 row 2 → addr 0x02A, fetch high until done. Return 0x76543210 → pixels 0,1,2,...,7 in order; sprite_ready_o low from accept until pending loads into the shifter.
- Streaming: pixel_ready_i=1, done one cycle after fetch rises, two tiles 0xAAAAAAAA then 0x55555555 → 16 consecutive valid cycles (8×A, 8×5), no bubble.
- Backpressure: toggle pixel_ready_i every cycle → every pixel delivered once, outputs stable while stalled. Row 9 issues addr with row bits = 1.
- Geometry: MAP_WIDTH=4, LINES=2 → eol on pixels 32 and 64 only; eof on pixel 64 only. Next pixel restarts at line 0 with no marker.
- frame_start mid-tile, with fetch outstanding and done in the same cycle → pixel_valid_o and spr_mem_fetch_o are 0 next cycle, data discarded. Next tile's first pixel emits with position 0.
- Async reset asserted mid-shift between clock edges → pixel_valid_o and spr_mem_fetch_o drop immediately. After release, sprite_ready_o=1.

Source files
------------

// File: rtl/vde_sprite_rasterizer.sv
// Sprite row rasterizer: fetches one 32-bit sprite row per tile request and
// serialises it as 4-bit palette indices with end-of-line / end-of-frame markers.
module vde_sprite_rasterizer #(
    parameter int unsigned MAP_WIDTH = 80,
    parameter int unsigned LINES     = 480
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        frame_start,
    input  logic        sprite_valid_i,
    output logic        sprite_ready_o,
    input  logic [8:0]  sprite_data_i,
    input  logic [3:0]  sprite_row_i,
    output logic [11:0] spr_mem_addr_o,
    output logic        spr_mem_fetch_o,
    input  logic [31:0] spr_mem_data_i,
    input  logic        spr_mem_done_i,
    output logic        pixel_valid_o,
    input  logic        pixel_ready_i,
    output logic [3:0]  pixel_o,
    output logic        pixel_eol_o,
    output logic        pixel_eof_o
);
    localparam int unsigned TXW = (MAP_WIDTH > 1) ? $clog2(MAP_WIDTH) : 1;
    localparam int unsigned LNW = (LINES > 1) ? $clog2(LINES) : 1;
    localparam logic [TXW-1:0] TX_LAST = TXW'(MAP_WIDTH - 1);
    localparam logic [LNW-1:0] LN_LAST = LNW'(LINES - 1);

    logic            fetch_q;
    logic [11:0]     addr_q;
    logic [31:0]     pending_q;
    logic            pending_valid;
    logic [31:0]     shifter_q;
    logic            shifter_valid;
    logic [2:0]      idx_q;
    logic [TXW-1:0]  tile_x;
    logic [LNW-1:0]  line_q;

    logic accept;
    logic mem_take;
    logic pix_accept;
    logic last_accept;
    logic load_shifter;

    // Row bit 3 addresses nothing inside an 8-row sprite.
    logic unused_row_msb;
    assign unused_row_msb = sprite_row_i[3];

    always_comb begin
        sprite_ready_o = ~frame_start & ~fetch_q & ~pending_valid;
        accept         = sprite_valid_i & sprite_ready_o;
        mem_take       = fetch_q & spr_mem_done_i;
        pix_accept     = shifter_valid & pixel_ready_i;
        last_accept    = pix_accept & (idx_q == 3'd7);
        load_shifter   = pending_valid & (~shifter_valid | last_accept);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_q <= 1'b0;
            addr_q  <= '0;
        end else if (frame_start) begin
            fetch_q <= 1'b0;
            addr_q  <= '0;
        end else if (mem_take) begin
            fetch_q <= 1'b0;
        end else if (accept) begin
            addr_q  <= {sprite_data_i, sprite_row_i[2:0]};
            fetch_q <= 1'b1;
        end
    end

    // A memory return may land on the same edge the old pending row moves
    // into the shifter; the new row wins and pending stays valid.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            pending_q     <= '0;
            pending_valid <= 1'b0;
        end else if (frame_start) begin
            pending_q     <= '0;
            pending_valid <= 1'b0;
        end else if (mem_take) begin
            pending_q     <= spr_mem_data_i;
            pending_valid <= 1'b1;
        end else if (load_shifter) begin
            pending_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            shifter_q     <= '0;
            shifter_valid <= 1'b0;
            idx_q         <= '0;
        end else if (frame_start) begin
            shifter_q     <= '0;
            shifter_valid <= 1'b0;
            idx_q         <= '0;
        end else if (load_shifter) begin
            shifter_q     <= pending_q;
            shifter_valid <= 1'b1;
            idx_q         <= '0;
        end else if (pix_accept) begin
            shifter_q <= {4'h0, shifter_q[31:4]};
            idx_q     <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
                shifter_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tile_x <= '0;
            line_q <= '0;
        end else if (frame_start) begin
            tile_x <= '0;
            line_q <= '0;
        end else if (last_accept) begin
            if (tile_x == TX_LAST) begin
                tile_x <= '0;
                line_q <= (line_q == LN_LAST) ? '0 : line_q + LNW'(1);
            end else begin
                tile_x <= tile_x + TXW'(1);
            end
        end
    end

    always_comb begin
        spr_mem_addr_o  = addr_q;
        spr_mem_fetch_o = fetch_q;
        pixel_valid_o   = shifter_valid;
        pixel_o         = shifter_q[3:0];
        pixel_eol_o     = shifter_valid & (idx_q == 3'd7) & (tile_x == TX_LAST);
        pixel_eof_o     = pixel_eol_o & (line_q == LN_LAST);
    end
endmodule
